// File: rtl/ram8_port_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM: round-robin
// grants with an optional bounded lock, zero-latency read return per requester.
module ram8_port_arbiter #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic              lock0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);
    localparam int CNT_W = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0] LOCK_CAP = CNT_W'(LOCK_MAX);

    logic [1:0]        req_v, we_v, lock_v, gnt_v;
    logic [ADDR_W-1:0] addr_v [2];
    logic [DATA_W-1:0] wdata_v [2];
    logic              rvalid_reg [2];
    logic [DATA_W-1:0] rdata_reg [2];
    logic [DATA_W-1:0] rdata_v [2];

    logic              win, any_gnt;
    logic              ptr_reg, ptr_next;
    logic              lock_active_reg, lock_active_next;
    logic              lock_id_reg, lock_id_next;
    logic [CNT_W-1:0]  lock_cnt_reg, lock_cnt_next;
    logic [ADDR_W-1:0] addr_hold_reg;
    logic [DATA_W-1:0] din_hold_reg;

    assign req_v      = {req1, req0};
    assign we_v       = {we1, we0};
    assign lock_v     = {lock1, lock0};
    assign addr_v[0]  = addr0;
    assign addr_v[1]  = addr1;
    assign wdata_v[0] = wdata0;
    assign wdata_v[1] = wdata1;

    assign gnt0    = gnt_v[0];
    assign gnt1    = gnt_v[1];
    assign rvalid0 = rvalid_reg[0];
    assign rvalid1 = rvalid_reg[1];
    assign rdata0  = rdata_v[0];
    assign rdata1  = rdata_v[1];

    // Contention: a lock holder keeps priority until it has used up LOCK_MAX
    // contended grants, otherwise the requester not granted last wins.
    always_comb begin
        win   = req_v[1];
        gnt_v = 2'b00;
        if (req_v == 2'b11) begin
            if (lock_active_reg)
                win = (lock_cnt_reg < LOCK_CAP) ? lock_id_reg : ~lock_id_reg;
            else
                win = ~ptr_reg;
        end
        if (rst_n && (req_v != 2'b00))
            gnt_v = win ? 2'b10 : 2'b01;
    end

    assign any_gnt  = |gnt_v;
    assign ram_we   = any_gnt & we_v[win];
    assign ram_addr = any_gnt ? addr_v[win] : addr_hold_reg;
    assign ram_din  = any_gnt ? wdata_v[win] : din_hold_reg;

    always_comb begin
        ptr_next         = any_gnt ? win : ptr_reg;
        lock_active_next = any_gnt & lock_v[win];
        lock_id_next     = any_gnt ? win : lock_id_reg;
        lock_cnt_next    = '0;
        // Only locked grants made while the other side waits use up the budget.
        if (any_gnt && lock_v[win] && req_v[~win]) begin
            if (lock_active_reg && (lock_id_reg == win))
                lock_cnt_next = (lock_cnt_reg == LOCK_CAP) ? LOCK_CAP
                                                           : lock_cnt_reg + CNT_W'(1);
            else
                lock_cnt_next = CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_reg         <= 1'b1;
            lock_active_reg <= 1'b0;
            lock_id_reg     <= 1'b0;
            lock_cnt_reg    <= '0;
            addr_hold_reg   <= '0;
            din_hold_reg    <= '0;
        end else begin
            ptr_reg         <= ptr_next;
            lock_active_reg <= lock_active_next;
            lock_id_reg     <= lock_id_next;
            lock_cnt_reg    <= lock_cnt_next;
            addr_hold_reg   <= ram_addr;
            din_hold_reg    <= ram_din;
        end
    end

    // Read return: ram_q is passed straight through in the valid cycle and
    // captured at its end so the value stays put until the next read.
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rvalid_reg[gi] <= 1'b0;
                rdata_reg[gi]  <= '0;
            end else begin
                rvalid_reg[gi] <= gnt_v[gi] & ~we_v[gi];
                if (rvalid_reg[gi])
                    rdata_reg[gi] <= ram_q;
            end
        end
        assign rdata_v[gi] = rvalid_reg[gi] ? ram_q : rdata_reg[gi];
    end
endmodule

// File: tb/tb_ram8_port_arbiter.sv
// Bench for ram8_port_arbiter: behavioural write-first RAM, shadow-memory
// scoreboard of expected read returns, directed and random traffic.
module tb_ram8_port_arbiter;
    localparam int ADDR_W   = 11;
    localparam int DATA_W   = 8;
    localparam int LOCK_MAX = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
    logic req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic gnt0, gnt1, rvalid0, rvalid1, ram_we;
    logic [DATA_W-1:0] rdata0, rdata1, ram_din;
    logic [DATA_W-1:0] ram_q = '0;
    logic [ADDR_W-1:0] ram_addr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              lock;
    } op_t;
    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    op_t  ops0[$], ops1[$];
    exp_t exp0[$], exp1[$];
    int   gnt_log[$];

    logic [DATA_W-1:0] ram_mem [2**ADDR_W];
    logic [DATA_W-1:0] shadow  [2**ADDR_W];
    logic [ADDR_W-1:0] last_addr = '0;

    ram8_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    // Synchronous write-first RAM, no output register.
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_q <= ram_we ? ram_din : ram_mem[ram_addr];
    end

    // Scoreboard monitor: pops expected reads on rvalid, pushes them on grants.
    always @(negedge clk) begin
        bit ev;
        cyc++;
        if (!rst_n) begin
            exp0.delete();
            exp1.delete();
            last_addr = '0;
        end else begin
            ev = (exp0.size() > 0) && (exp0[0].due == cyc);
            if (rvalid0 || ev) begin
                checks++;
                if (rvalid0 !== ev || (ev && rdata0 !== exp0[0].data)) begin
                    failures++;
                    $display("FAIL rd0 cyc=%0d got rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                             cyc, rvalid0, rdata0, ev, ev ? exp0[0].data : 8'h00);
                end
                if (ev) void'(exp0.pop_front());
            end
            ev = (exp1.size() > 0) && (exp1[0].due == cyc);
            if (rvalid1 || ev) begin
                checks++;
                if (rvalid1 !== ev || (ev && rdata1 !== exp1[0].data)) begin
                    failures++;
                    $display("FAIL rd1 cyc=%0d got rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                             cyc, rvalid1, rdata1, ev, ev ? exp1[0].data : 8'h00);
                end
                if (ev) void'(exp1.pop_front());
            end
            checks++;
            if ((gnt0 && gnt1) || (gnt0 && !req0) || (gnt1 && !req1)) begin
                failures++;
                $display("FAIL gnt_legal cyc=%0d got gnt=%b%b req=%b%b want one-hot subset of req",
                         cyc, gnt1, gnt0, req1, req0);
            end
            if (gnt0 || gnt1) begin
                logic              g_we;
                logic [ADDR_W-1:0] g_addr;
                logic [DATA_W-1:0] g_din;
                g_we   = gnt0 ? we0 : we1;
                g_addr = gnt0 ? addr0 : addr1;
                g_din  = gnt0 ? wdata0 : wdata1;
                checks++;
                if (ram_addr !== g_addr || ram_din !== g_din || ram_we !== g_we) begin
                    failures++;
                    $display("FAIL ram_side cyc=%0d got addr=%h din=%h we=%b want addr=%h din=%h we=%b",
                             cyc, ram_addr, ram_din, ram_we, g_addr, g_din, g_we);
                end
                if (g_we) shadow[g_addr] = g_din;
                else if (gnt0) exp0.push_back('{shadow[g_addr], cyc + 1});
                else exp1.push_back('{shadow[g_addr], cyc + 1});
                last_addr = g_addr;
            end else begin
                checks++;
                if (ram_we !== 1'b0 || ram_addr !== last_addr) begin
                    failures++;
                    $display("FAIL ram_idle cyc=%0d got we=%b addr=%h want we=0 addr=%h",
                             cyc, ram_we, ram_addr, last_addr);
                end
            end
        end
    end

    // Drives queued ops, each held until granted; logs grant order and waits.
    task automatic run_ops(input int max_cyc);
        int w0 = 0, w1 = 0, n = 0;
        while (ops0.size() > 0 || ops1.size() > 0) begin
            if (n >= max_cyc) begin
                checks++;
                failures++;
                $display("FAIL run_timeout got %0d/%0d ops left want 0", ops0.size(), ops1.size());
                break;
            end
            req0 = ops0.size() > 0;
            if (req0) begin
                we0 = ops0[0].we; addr0 = ops0[0].addr; wdata0 = ops0[0].wdata; lock0 = ops0[0].lock;
            end else lock0 = 1'b0;
            req1 = ops1.size() > 0;
            if (req1) begin
                we1 = ops1[0].we; addr1 = ops1[0].addr; wdata1 = ops1[0].wdata; lock1 = ops1[0].lock;
            end else lock1 = 1'b0;
            @(negedge clk);
            if (gnt0) begin
                gnt_log.push_back(0);
                checks++;
                if (w0 > LOCK_MAX + 1) begin
                    failures++;
                    $display("FAIL wait0 got %0d cycles want <= %0d", w0, LOCK_MAX + 1);
                end
                w0 = 0;
                void'(ops0.pop_front());
            end else if (req0) w0++;
            if (gnt1) begin
                gnt_log.push_back(1);
                checks++;
                if (w1 > LOCK_MAX + 1) begin
                    failures++;
                    $display("FAIL wait1 got %0d cycles want <= %0d", w1, LOCK_MAX + 1);
                end
                w1 = 0;
                void'(ops1.pop_front());
            end else if (req1) w1++;
            n++;
            @(posedge clk); #1;
        end
        req0 = 1'b0; req1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 11'h005; wdata0 = 8'h33; req1 = 1'b1;
        #2;
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || ram_we !== 1'b0 || ram_addr !== '0 || ram_din !== '0) begin
            failures++;
            $display("FAIL reset_ram got gnt=%b%b we=%b addr=%h din=%h want all 0",
                     gnt1, gnt0, ram_we, ram_addr, ram_din);
        end
        checks++;
        if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata0 !== '0 || rdata1 !== '0) begin
            failures++;
            $display("FAIL reset_rd got rvalid=%b%b rdata0=%h rdata1=%h want all 0",
                     rvalid1, rvalid0, rdata0, rdata1);
        end
        req0 = 1'b0; we0 = 1'b0; req1 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        int want[$] = '{0, 1, 0, 1};
        gnt_log.delete();
        ops0.push_back('{1'b0, 11'h010, 8'h00, 1'b0});
        ops0.push_back('{1'b0, 11'h011, 8'h00, 1'b0});
        ops1.push_back('{1'b0, 11'h020, 8'h00, 1'b0});
        ops1.push_back('{1'b0, 11'h021, 8'h00, 1'b0});
        run_ops(20);
        checks++;
        if (gnt_log.size() != want.size()) begin
            failures++;
            $display("FAIL rr_len got %0d want %0d", gnt_log.size(), want.size());
        end
        for (int i = 0; i < want.size() && i < gnt_log.size(); i++) begin
            checks++;
            if (gnt_log[i] != want[i]) begin
                failures++;
                $display("FAIL rr_order[%0d] got %0d want %0d", i, gnt_log[i], want[i]);
            end
        end
    endtask

    task automatic test_single_read();
        req0 = 1'b1; we0 = 1'b0; addr0 = 11'h000; lock0 = 1'b0;
        #4;
        checks++;
        if (gnt0 !== 1'b1 || ram_addr !== 11'h000 || ram_we !== 1'b0) begin
            failures++;
            $display("FAIL single_gnt got gnt0=%b addr=%h we=%b want 1 000 0", gnt0, ram_addr, ram_we);
        end
        @(posedge clk); #1;
        req0 = 1'b0;
        #4;
        checks++;
        if (rvalid0 !== 1'b1 || rdata0 !== 8'h48) begin
            failures++;
            $display("FAIL single_rd got rvalid0=%b rdata0=%h want 1 48", rvalid0, rdata0);
        end
        @(posedge clk); #5;
        checks++;
        if (rvalid0 !== 1'b0 || rdata0 !== 8'h48) begin
            failures++;
            $display("FAIL single_hold got rvalid0=%b rdata0=%h want 0 48", rvalid0, rdata0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_then_read();
        ops1.push_back('{1'b1, 11'h7FF, 8'hA5, 1'b0});
        ops1.push_back('{1'b0, 11'h7FF, 8'h00, 1'b0});
        run_ops(10);
        #4;
        checks++;
        if (rvalid1 !== 1'b0 || rdata1 !== 8'hA5 || rvalid0 !== 1'b0) begin
            failures++;
            $display("FAIL wr_rd_hold got rvalid1=%b rdata1=%h rvalid0=%b want 0 a5 0",
                     rvalid1, rdata1, rvalid0);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_lock();
        int want[$];
        gnt_log.delete();
        for (int i = 0; i < 20; i++)
            ops0.push_back('{1'b0, 11'(i + 64), 8'h00, (i < LOCK_MAX) ? 1'b1 : 1'b0});
        for (int i = 0; i < 4; i++)
            ops1.push_back('{1'b0, 11'(i + 96), 8'h00, 1'b0});
        for (int i = 0; i < LOCK_MAX; i++) want.push_back(0);
        for (int i = 0; i < 4; i++) begin want.push_back(1); want.push_back(0); end
        run_ops(60);
        checks++;
        if (gnt_log.size() != want.size()) begin
            failures++;
            $display("FAIL lock_len got %0d want %0d", gnt_log.size(), want.size());
        end
        for (int i = 0; i < want.size() && i < gnt_log.size(); i++) begin
            checks++;
            if (gnt_log[i] != want[i]) begin
                failures++;
                $display("FAIL lock_order[%0d] got %0d want %0d", i, gnt_log[i], want[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        req0 = 1'b1; we0 = 1'b0; addr0 = 11'h000; lock0 = 1'b0;
        #4;
        checks++;
        if (gnt0 !== 1'b1) begin
            failures++;
            $display("FAIL mid_gnt got gnt0=%b want 1", gnt0);
        end
        @(posedge clk); #1;
        we0 = 1'b1; wdata0 = 8'hEE;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rvalid0 !== 1'b0 || rdata0 !== 8'h00 || ram_we !== 1'b0 || gnt0 !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got rvalid0=%b rdata0=%h we=%b gnt0=%b want 0 00 0 0",
                     rvalid0, rdata0, ram_we, gnt0);
        end
        req0 = 1'b0; we0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 11'h7FF; lock1 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL mid_hold got gnt1=%b want 0", gnt1);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #3;
        checks++;
        if (gnt1 !== 1'b1 || rvalid0 !== 1'b0) begin
            failures++;
            $display("FAIL mid_first got gnt1=%b rvalid0=%b want 1 0", gnt1, rvalid0);
        end
        @(posedge clk); #1;
        req1 = 1'b0;
        #4;
        checks++;
        if (rvalid0 !== 1'b0 || rvalid1 !== 1'b1 || rdata1 !== 8'hA5) begin
            failures++;
            $display("FAIL mid_after got rvalid0=%b rvalid1=%b rdata1=%h want 0 1 a5",
                     rvalid0, rvalid1, rdata1);
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            ops0.push_back('{1'($urandom_range(0, 1)),
                             ($urandom_range(0, 9) == 0) ? 11'h7FF : 11'($urandom_range(0, 15)),
                             8'($urandom), ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0});
            ops1.push_back('{1'($urandom_range(0, 1)),
                             ($urandom_range(0, 9) == 0) ? 11'h7FF : 11'($urandom_range(0, 15)),
                             8'($urandom), ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0});
        end
        run_ops(400);
    endtask

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) begin
            ram_mem[i] = 8'(i * 7 + 3);
            shadow[i]  = 8'(i * 7 + 3);
        end
        ram_mem[0] = 8'h48;
        shadow[0]  = 8'h48;
        test_reset();
        test_round_robin();
        test_single_read();
        test_write_then_read();
        test_lock();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ram8_port_arbiter.md
RAM8_PORT_ARBITER -- requirements
Module: ram8_port_arbiter

Interface
REQ-001 Parameter: ADDR_W, 11, RAM word address width (2K x 8).
REQ-002 Parameter: DATA_W, 8, RAM data width.
REQ-003 Parameter: LOCK_MAX, 16, maximum consecutive locked grants to one requester while the other requests.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset; ports: clk  in  1  rising-edge clock (shared with RAM); rst_n  in  1  asynchronous active-low reset.
REQ-005 Per requester N in {0,1}: reqN  in  1  access request; weN  in  1  1 = write, 0 = read; lockN  in  1  request to keep grant on next access.
REQ-006 addrN  in  ADDR_W  word address; wdataN  in  DATA_W  write data.
REQ-007 gntN  out  1  access accepted this cycle; rvalidN  out  1  read data valid pulse; rdataN  out  DATA_W  read data.
REQ-008 RAM side: ram_addr  out  ADDR_W; ram_din  out  DATA_W; ram_we  out  1; ram_q  in  DATA_W  synchronous RAM read data (no output register, write-first).

Function
REQ-009 Arbitration SHALL be combinational within the cycle: at most one of gnt0/gnt1 high; gntN only when reqN high.
REQ-010 Single requester: gnt to it in the same cycle, every cycle, no bubbles.
REQ-011 Both requesting, no lock in force: grant the requester not granted last (round robin); ptr register updates on every grant.
REQ-012 Granted cycle T: ram_addr/ram_din/ram_we SHALL equal granted addrN/wdataN/weN; no grant -> ram_we=0, ram_addr/ram_din hold last driven values.
REQ-013 Read granted in T: rvalidN SHALL pulse high for exactly cycle T+1, with rdataN = ram_q in T+1 (zero added latency).
REQ-014 rdataN SHALL be captured at end of T+1 and held stable until that requester's next rvalid; the other requester's rdata unaffected.
REQ-015 Writes SHALL produce no rvalid; a read granted in T+1 to same address returns the data written in T.
REQ-016 Back-to-back reads (T, T+1) SHALL yield rvalid in T+1 and T+2 with correct data each; throughput one access per cycle.
REQ-017 Lock: if gntN and lockN in T, requester N SHALL hold priority in T+1 over the other requester; lock ends when lockN=0 on a grant or reqN drops.
REQ-018 Lock counter SHALL count consecutive locked grants to N while the other requester is requesting; after LOCK_MAX such grants the next contended cycle SHALL go to the other requester and the counter clears.
REQ-019 Counter SHALL clear on any grant to the other requester or when the other requester is idle; it never wraps past LOCK_MAX.
REQ-020 Address and data SHALL pass unmodified; ADDR_W-bit addresses wrap naturally at 0x7FF (no range check).
REQ-021 Request inputs are sampled only in the granted cycle; a requester not granted SHALL keep req asserted with stable fields until gnt.

Reset
REQ-022 rst_n low SHALL asynchronously force: gnt0/gnt1=0, ram_we=0, rvalid0/1=0, rdata0/1=0, ram_addr=0, ram_din=0, lock counter=0, lock state cleared, ptr = "last granted 1" (so first contended grant goes to requester 0).
REQ-023 A read granted in the cycle before reset assertion SHALL produce no rvalid after reset release.
REQ-024 First grant possible in the first rising edge cycle after rst_n deasserts.

Verification
REQ-025 RAM model preloaded 0x48 at 0x000; req0 read 0x000 alone -> gnt0 in T, rvalid0=1 and rdata0=0x48 in T+1, rdata0 holds 0x48 afterwards.
REQ-026 After reset, req0 and req1 both held high for 4 reads -> grant order 0,1,0,1; each rvalid in the cycle after its grant.
REQ-027 req1 write 0xA5 to 0x7FF in T, read 0x7FF in T+1 -> no rvalid1 in T+1, rvalid1 with rdata1=0xA5 in T+2.
REQ-028 req0 with lock0=1 and req1 continuously high -> gnt0 for 16 consecutive cycles, gnt1 in cycle 17, then round robin resumes.
REQ-029 req0 read granted in T, rst_n low in T+1 -> rvalid0=0, rdata0=0x00, ram_we=0 immediately; after release, req1 alone gets grant in first cycle.
REQ-030 Random both-requester traffic vs. scoreboard memory model -> every read matches, never both gnt high, no requester waits more than LOCK_MAX+1 cycles.
